map_server: RTL



---
 rtl/tank_pkg.sv | 33 +++
 rtl/map_wr_fifo.sv | 62 ++++++
 rtl/map_server.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// Shared map types and constants for the tank game field.
// MAP_SERVER_DEFAULT_MAZE_EN adds the built-in interior obstacle pattern.
package tank_pkg;

  localparam int unsigned MAP_W             = 64;
  localparam int unsigned MAP_H             = 44;
  localparam int unsigned STATUS_BAR_HEIGHT = 4;

  typedef logic [5:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   wall;
  } wr_req_t;

`ifdef MAP_SERVER_DEFAULT_MAZE_EN
  function automatic logic [MAP_W-1:0] maze_row(input coord_t r);
    logic [MAP_W-1:0] v;
    v = '0;
    if (r == 6'd10 || r == 6'd22 || r == 6'd33) begin
      v[23:16] = '1;
      v[47:40] = '1;
    end
    if ((r >= 6'd5 && r <= 6'd15) || (r >= 6'd28 && r <= 6'd38)) begin
      v[31] = 1'b1;
      v[32] = 1'b1;
    end
    return v;
  endfunction
`endif

endpackage

// File: rtl/map_wr_fifo.sv
// Synchronous FIFO of pending wall edits; DEPTH must be a power of 2.
module map_wr_fifo
  import tank_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  wr_req_t                data_i,
  input  logic                   pop_i,
  output wr_req_t                data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  wr_req_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/map_server.sv
// Wall-bitmap responder for the VGA map-request interface; edits commit only in blanking.
// MAP_SERVER_DEFAULT_MAZE_EN enables the default interior maze during INIT.
module map_server
  import tank_pkg::*;
#(
  parameter int unsigned MAP_W      = 64,
  parameter int unsigned MAP_H      = 44,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_buzy,
  input  logic [5:0]                  i_request_x,
  input  logic [5:0]                  i_request_y,
  output logic                        o_is_wall,
  input  logic                        i_wr_valid,
  output logic                        o_wr_ready,
  input  logic [5:0]                  i_wr_x,
  input  logic [5:0]                  i_wr_y,
  input  logic                        i_wr_wall,
  output logic                        o_init_done,
  output logic [$clog2(FIFO_DEPTH):0] o_pending
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [6:0] W7       = 7'(MAP_W);
  localparam logic [6:0] H7       = 7'(MAP_H);
  localparam coord_t     LAST_ROW = coord_t'(MAP_H - 1);

  state_e           state_q, state_d;
  coord_t           row_q, row_d;
  logic             init_we;
  logic [MAP_W-1:0] init_row;
  logic [MAP_W-1:0] map_q [MAP_H];
  logic             is_wall_q;
  logic             init_done_q;

  wr_req_t wr_req, head;
  logic    fifo_full, fifo_empty, pop, head_interior, req_oor;

  assign wr_req = '{x: i_wr_x, y: i_wr_y, wall: i_wr_wall};

  map_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (i_wr_valid && o_wr_ready),
    .data_i  (wr_req),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_pending)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    init_we = 1'b0;
    case (state_q)
      INIT: begin
        init_we = 1'b1;
        row_d   = row_q + 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = RUN;
          row_d   = '0;
        end
      end
      RUN:     ;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      row_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      init_done_q <= (state_q == RUN);
    end
  end

  always_comb begin
    if (row_q == '0 || row_q == LAST_ROW) begin
      init_row = '1;
    end else begin
      init_row = {1'b1, {(MAP_W-2){1'b0}}, 1'b1};
    end
`ifdef MAP_SERVER_DEFAULT_MAZE_EN
    init_row = init_row | maze_row(row_q);
`endif
  end

  // Border cells are indestructible, so only strictly interior edits reach the map.
  assign pop           = (state_q == RUN) && !i_buzy && !fifo_empty;
  assign head_interior = ({1'b0, head.x} >= 7'd1) && ({1'b0, head.x} < W7 - 7'd1) &&
                         ({1'b0, head.y} >= 7'd1) && ({1'b0, head.y} < H7 - 7'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we) begin
        map_q[row_q] <= init_row;
      end else if (pop && head_interior) begin
        map_q[head.y][head.x] <= head.wall;
      end
    end
  end

  assign req_oor = ({1'b0, i_request_x} >= W7) || ({1'b0, i_request_y} >= H7);

  always_ff @(posedge clk) begin
    if (rst) begin
      is_wall_q <= 1'b1;
    end else if (state_q != RUN || req_oor) begin
      is_wall_q <= 1'b1;
    end else begin
      is_wall_q <= map_q[i_request_y][i_request_x];
    end
  end

  assign o_is_wall   = is_wall_q;
  assign o_init_done = init_done_q;
  assign o_wr_ready  = (state_q == RUN) && !fifo_full;

endmodule
